// File: rtl/histeq_param_engine_if.sv
// Job control and memory bus of the histogram-equalisation engine.
// The engine side is the master: it drives status and both memory ports.
`timescale 1ns/1ps
interface histeq_param_engine_if #(
  parameter int PIX_W   = 8,
  parameter int LANES   = 16,
  parameter int COUNT_W = 32
);
  localparam int DW = LANES * PIX_W;

  logic               start;
  logic [15:0]        num_words;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] cdf_min;
  logic [15:0]        in_mem_raddr;
  logic [DW-1:0]      in_mem_rdata;
  logic               out_mem_WE;
  logic [15:0]        out_mem_waddr;
  logic [DW-1:0]      out_mem_wdata;

  modport master (
    input  start, num_words, in_mem_rdata,
    output busy, done, error, cdf_min, in_mem_raddr,
           out_mem_WE, out_mem_waddr, out_mem_wdata
  );
  modport slave (
    output start, num_words, in_mem_rdata,
    input  busy, done, error, cdf_min, in_mem_raddr,
           out_mem_WE, out_mem_waddr, out_mem_wdata
  );
endinterface

// File: rtl/histeq_param_engine.sv
// Self-sequencing histogram equalisation: histogram, CDF, LUT divide, remap.
// Optional macro HISTEQ_CLIP_EN saturates each bin at CLIP_LIMIT (contrast limiting).
`timescale 1ns/1ps
module histeq_param_engine #(
  parameter int PIX_W      = 8,
  parameter int LANES      = 16,
  parameter int COUNT_W    = 32,
  parameter int CLIP_LIMIT = 1024
) (
  input logic                      clock,
  input logic                      reset,
  histeq_param_engine_if.master    bus_io
);
  localparam int BINS = 2 ** PIX_W;
  localparam int DW   = LANES * PIX_W;
  localparam int NW   = COUNT_W + PIX_W;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DCW  = $clog2(NW + 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, H_REQ, H_LOAD, H_ACC, CDF, LUT, M_REQ, M_LOAD, M_ACC, M_WR, FIN
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        nw_q, w_q;
  logic [LW-1:0]      lane_q;
  logic [PIX_W-1:0]   bidx_q;
  logic [DCW-1:0]     dcnt_q;
  logic [DW-1:0]      sh_q, ow_q;
  logic [COUNT_W-1:0] bins_q [BINS];
  logic [PIX_W-1:0]   lut_q  [BINS];
  logic [COUNT_W-1:0] acc_q, cdfmin_q, total_q, rem_q;
  logic [NW-1:0]      nq_q;
  logic               err_q;

  logic               last_lane, last_word, last_bin, last_step, degen, ge;
  logic [PIX_W-1:0]   pix;
  logic [COUNT_W-1:0] cdf_b, sum, diff, den, rem_src, rem_n;
  logic [NW-1:0]      num_new, num_src, nq_n;
  logic [COUNT_W:0]   rem_sh;

  assign last_lane = lane_q == LW'(LANES - 1);
  assign last_word = (w_q + 16'd1) == nw_q;
  assign last_bin  = bidx_q == PIX_W'(BINS - 1);
  assign last_step = dcnt_q == DCW'(NW - 1);
  assign degen     = total_q == cdfmin_q;
  assign pix       = sh_q[PIX_W-1:0];

  // One restoring-divide step per cycle; the first step of each bin takes its
  // operands straight from the CDF so a bin costs exactly NW cycles.
  always_comb begin
    cdf_b   = bins_q[bidx_q];
    sum     = acc_q + cdf_b;
    diff    = (cdf_b >= cdfmin_q) ? cdf_b - cdfmin_q : '0;
    num_new = ({{PIX_W{1'b0}}, diff} << PIX_W) - {{PIX_W{1'b0}}, diff};
    num_src = (dcnt_q == '0) ? num_new : nq_q;
    rem_src = (dcnt_q == '0) ? '0 : rem_q;
    den     = total_q - cdfmin_q;
    rem_sh  = {rem_src, num_src[NW-1]};
    ge      = rem_sh >= {1'b0, den};
    rem_n   = ge ? COUNT_W'(rem_sh - {1'b0, den}) : rem_sh[COUNT_W-1:0];
    nq_n    = {num_src[NW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus_io.start) state_d = (bus_io.num_words == '0) ? FIN : CLEAR;
      CLEAR:  state_d = H_REQ;
      H_REQ:  state_d = H_LOAD;
      H_LOAD: state_d = H_ACC;
      H_ACC:  if (last_lane) state_d = last_word ? CDF : H_REQ;
      CDF:    if (last_bin) state_d = LUT;
      LUT:    if (last_bin && (degen || last_step)) state_d = M_REQ;
      M_REQ:  state_d = M_LOAD;
      M_LOAD: state_d = M_ACC;
      M_ACC:  if (last_lane) state_d = M_WR;
      M_WR:   state_d = last_word ? FIN : M_REQ;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      nw_q     <= '0;
      w_q      <= '0;
      lane_q   <= '0;
      bidx_q   <= '0;
      dcnt_q   <= '0;
      sh_q     <= '0;
      ow_q     <= '0;
      acc_q    <= '0;
      cdfmin_q <= '0;
      total_q  <= '0;
      rem_q    <= '0;
      nq_q     <= '0;
      err_q    <= 1'b0;
      for (int b = 0; b < BINS; b++) begin
        bins_q[b] <= '0;
        lut_q[b]  <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus_io.start) begin
          nw_q     <= bus_io.num_words;
          err_q    <= bus_io.num_words == '0;
          cdfmin_q <= '0;
          w_q      <= '0;
        end
        CLEAR: begin
          for (int b = 0; b < BINS; b++) bins_q[b] <= '0;
          acc_q  <= '0;
          bidx_q <= '0;
        end
        H_LOAD, M_LOAD: begin
          sh_q   <= bus_io.in_mem_rdata;
          lane_q <= '0;
        end
        H_ACC: begin
`ifdef HISTEQ_CLIP_EN
          if (bins_q[pix] < COUNT_W'(CLIP_LIMIT)) bins_q[pix] <= bins_q[pix] + COUNT_W'(1);
`else
          bins_q[pix] <= bins_q[pix] + COUNT_W'(1);
`endif
          sh_q   <= sh_q >> PIX_W;
          lane_q <= lane_q + LW'(1);
          if (last_lane) w_q <= last_word ? 16'd0 : w_q + 16'd1;
        end
        CDF: begin
          bins_q[bidx_q] <= sum;
          acc_q          <= sum;
          bidx_q         <= bidx_q + PIX_W'(1);
          dcnt_q         <= '0;
          if (cdfmin_q == '0 && sum != '0) cdfmin_q <= sum;
          if (last_bin) total_q <= sum;
        end
        LUT: begin
          if (degen) begin
            lut_q[bidx_q] <= bidx_q;
            bidx_q        <= bidx_q + PIX_W'(1);
          end else begin
            rem_q  <= rem_n;
            nq_q   <= nq_n;
            dcnt_q <= dcnt_q + DCW'(1);
            if (last_step) begin
              lut_q[bidx_q] <= nq_n[PIX_W-1:0];
              bidx_q        <= bidx_q + PIX_W'(1);
              dcnt_q        <= '0;
            end
          end
        end
        M_ACC: begin
          ow_q   <= {lut_q[pix], ow_q[DW-1:PIX_W]};
          sh_q   <= sh_q >> PIX_W;
          lane_q <= lane_q + LW'(1);
        end
        M_WR: w_q <= w_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus_io.busy          = (state_q != IDLE) && (state_q != FIN);
  assign bus_io.done          = state_q == FIN;
  assign bus_io.error         = (state_q == FIN) && err_q;
  assign bus_io.cdf_min       = cdfmin_q;
  assign bus_io.in_mem_raddr  = w_q;
  assign bus_io.out_mem_WE    = state_q == M_WR;
  assign bus_io.out_mem_waddr = w_q;
  assign bus_io.out_mem_wdata = ow_q;
endmodule

// File: tb/tb_histeq_param_engine.sv
// Directed plus random jobs checked against an arithmetic equalisation model.
`timescale 1ns/1ps
module tb_histeq_param_engine;
  localparam int PIX_W = 8, LANES = 16, COUNT_W = 32;
  localparam int DW = LANES * PIX_W, BINS = 2 ** PIX_W;
`ifdef HISTEQ_CLIP_EN
  localparam int    CLIP = 4;
  localparam longint LIM = 4;
`else
  localparam int    CLIP = 1024;
  localparam longint LIM = 64'h0000_7fff_ffff_ffff;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  histeq_param_engine_if #(.PIX_W(PIX_W), .LANES(LANES), .COUNT_W(COUNT_W)) bus ();
  histeq_param_engine #(.PIX_W(PIX_W), .LANES(LANES), .COUNT_W(COUNT_W), .CLIP_LIMIT(CLIP))
    dut (.clock(clock), .reset(reset), .bus_io(bus));

  logic [DW-1:0] in_mem  [16];
  logic [DW-1:0] out_mem [16];
  logic [DW-1:0] exp_out [16];
  longint        exp_cmin;
  logic [15:0]   wa_log [$];
  int tests = 0, fails = 0, we_cnt = 0, done_cnt = 0;

  always @(posedge clock) bus.in_mem_rdata <= in_mem[bus.in_mem_raddr[3:0]];

  always @(negedge clock) begin
    if (bus.out_mem_WE) begin
      out_mem[bus.out_mem_waddr[3:0]] <= bus.out_mem_wdata;
      wa_log.push_back(bus.out_mem_waddr);
      we_cnt <= we_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  // Equalisation straight from the definition: counts, running sum, scaled ratio.
  task automatic model(input int nw);
    longint h[BINS];
    longint cdf[BINS];
    longint c, tot;
    logic [PIX_W-1:0] lut[BINS];
    int p;
    for (int b = 0; b < BINS; b++) h[b] = 0;
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < LANES; k++) begin
        p = int'(in_mem[w][k*PIX_W +: PIX_W]);
        if (h[p] < LIM) h[p]++;
      end
    c = 0; exp_cmin = 0;
    for (int b = 0; b < BINS; b++) begin
      c += h[b];
      cdf[b] = c;
      if (exp_cmin == 0 && c != 0) exp_cmin = c;
    end
    tot = c;
    for (int b = 0; b < BINS; b++) begin
      if (tot == exp_cmin)     lut[b] = PIX_W'(b);
      else if (cdf[b] < exp_cmin) lut[b] = '0;
      else lut[b] = PIX_W'((cdf[b] - exp_cmin) * (BINS - 1) / (tot - exp_cmin));
    end
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < LANES; k++)
        exp_out[w][k*PIX_W +: PIX_W] = lut[int'(in_mem[w][k*PIX_W +: PIX_W])];
  endtask

  task automatic run_job(input string tag, input int nw, input bit hammer);
    int bw, bd;
    bit got;
    if (nw != 0) model(nw);
    bw = we_cnt; bd = done_cnt;
    wa_log.delete();
    for (int i = 0; i < 16; i++) out_mem[i] = '0;
    @(negedge clock);
    bus.num_words = 16'(nw);
    bus.start     = 1'b1;
    tick(1);
    if (!hammer) bus.start = 1'b0;
    check({tag, ":busy_after_start"}, DW'(bus.busy), DW'(nw != 0));
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (bus.done) begin got = 1'b1; break; end
      if (hammer) bus.start = bus.busy;
      tick(1);
    end
    bus.start = 1'b0;
    check({tag, ":done_seen"}, DW'(got), DW'(1));
    check({tag, ":error_with_done"}, DW'(bus.error), DW'(nw == 0));
    check({tag, ":busy_at_done"}, DW'(bus.busy), DW'(0));
    tick(3);
    check({tag, ":we_count"}, DW'(we_cnt - bw), DW'(nw));
    check({tag, ":done_count"}, DW'(done_cnt - bd), DW'(1));
    check({tag, ":busy_idle"}, DW'(bus.busy), DW'(0));
    if (nw != 0) begin
      check({tag, ":cdf_min"}, DW'(bus.cdf_min), DW'(exp_cmin));
      for (int w = 0; w < nw; w++) begin
        check({tag, ":word"}, out_mem[w], exp_out[w]);
        if (wa_log.size() > w) check({tag, ":waddr"}, DW'(wa_log[w]), DW'(w));
      end
    end
  endtask

  task automatic load_ramp(input int nw);
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < LANES; k++) in_mem[w][k*PIX_W +: PIX_W] = PIX_W'(k);
  endtask

  task automatic load_rand(input int nw, input int lo, input int hi);
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < LANES; k++)
        in_mem[w][k*PIX_W +: PIX_W] = PIX_W'($urandom_range(hi, lo));
  endtask

  initial begin
    int bw, bd, nw;
    bus.start = 1'b0;
    bus.num_words = '0;
    for (int i = 0; i < 16; i++) begin in_mem[i] = '0; out_mem[i] = '0; end
    tick(3);
    check("rst:busy",  DW'(bus.busy), DW'(0));
    check("rst:done",  DW'(bus.done), DW'(0));
    check("rst:error", DW'(bus.error), DW'(0));
    check("rst:cdf_min", DW'(bus.cdf_min), DW'(0));
    check("rst:raddr", DW'(bus.in_mem_raddr), DW'(0));
    check("rst:waddr", DW'(bus.out_mem_waddr), DW'(0));
    check("rst:we",    DW'(bus.out_mem_WE), DW'(0));
    check("rst:wdata", bus.out_mem_wdata, DW'(0));
    reset = 1'b0;
    tick(2);

    // T1: ramp 0..15 in every word
    load_ramp(4);
    run_job("T1", 4, 1'b0);
    check("T1:cdf_min_const", DW'(bus.cdf_min), DW'(4));
    check("T1:lane0", DW'(out_mem[0][7:0]), DW'(8'h00));
    check("T1:lane1", DW'(out_mem[0][15:8]), DW'(8'h11));
    check("T1:lane15", DW'(out_mem[3][127:120]), DW'(8'hFF));

    // T2: single intensity, identity mapping
    for (int w = 0; w < 2; w++) in_mem[w] = {LANES{8'h80}};
    run_job("T2", 2, 1'b0);
    check("T2:lanes", out_mem[1], {LANES{8'h80}});
`ifndef HISTEQ_CLIP_EN
    check("T2:cdf_min_const", DW'(bus.cdf_min), DW'(32));
`endif

    // T3: empty job
    run_job("T3", 0, 1'b0);

    // T4: reset during histogram accumulation
    load_ramp(4);
    bw = we_cnt; bd = done_cnt;
    @(negedge clock);
    bus.num_words = 16'd4;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    check("T4:rst_busy",  DW'(bus.busy), DW'(0));
    check("T4:rst_done",  DW'(bus.done), DW'(0));
    check("T4:rst_cdf_min", DW'(bus.cdf_min), DW'(0));
    check("T4:rst_raddr", DW'(bus.in_mem_raddr), DW'(0));
    check("T4:rst_we",    DW'(bus.out_mem_WE), DW'(0));
    check("T4:rst_wdata", bus.out_mem_wdata, DW'(0));
    reset = 1'b0;
    tick(40);
    check("T4:no_we_after_abort", DW'(we_cnt - bw), DW'(0));
    check("T4:no_done_after_abort", DW'(done_cnt - bd), DW'(0));
    run_job("T4_rerun", 4, 1'b0);
    check("T4:lane1", DW'(out_mem[2][15:8]), DW'(8'h11));

    // T5: start held high through the whole job
    run_job("T5", 4, 1'b1);
    tick(20);
    check("T5:no_restart", DW'(bus.busy), DW'(0));

    // Random jobs: full range, then a narrow band
    nw = $urandom_range(4, 1);
    load_rand(nw, 0, 255);
    run_job("R1", nw, 1'b0);
    nw = $urandom_range(4, 1);
    load_rand(nw, 60, 63);
    run_job("R2", nw, 1'b0);

`ifdef HISTEQ_CLIP_EN
    // T6: clipped counts
    in_mem[0] = {LANES{8'h10}};
    in_mem[1] = {8'h20, {(LANES-1){8'h10}}};
    run_job("T6", 2, 1'b0);
    check("T6:cdf_min_const", DW'(bus.cdf_min), DW'(4));
    check("T6:low", DW'(out_mem[0][7:0]), DW'(8'h00));
    check("T6:high", DW'(out_mem[1][127:120]), DW'(8'hFF));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
